fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
//
// PURPOSE
//   Instruction fetch sequencer. It sits directly downstream of pointer_pair's
//   IP half and drives that block's oe_addr_ip and cnt controls. Each cycle it
//   either reads one byte from memory at addr_out=IP or waits.
//   It assembles an opcode plus 0/1/2 immediate bytes into ir/imm and hands the
//   result to the execute stage with a valid/ready handshake.
//
// PARAMETERS
//   (none; all widths fixed: 8-bit data, 16-bit address)
//
// PORTS
//   clk           in   1   system clock; all state changes on rising edge
//   rst           in   1   asynchronous, active-low reset
//   mem_di        in   8   memory read data (data bus)
//   mem_ready     in   1   1 = mem_di valid this cycle
//   flush         in   1   1 = discard in-flight instruction (jump/IP reload)
//   ir_ready      in   1   1 = execute accepts ir/imm this cycle
//   mem_oe        out  1   active-low memory read enable
//   oe_addr_ip    out  1   active-low; to pointer_pair, puts IP on address bus
//   cnt           out  1   active-high; to pointer_pair, increments IP on edge
//   ir            out  8   latched opcode
//   imm           out  16  latched immediate; unused bytes read 0
//   ir_valid      out  1   1 = ir/imm hold a complete instruction
//
// BEHAVIOUR
//   - States: S_RST, S_OP, S_LO, S_HI, S_HOLD.
//   - Reset (rst=0, async): state=S_RST, ir=0, imm=0, ir_valid=0.
//     In S_RST: mem_oe=1, oe_addr_ip=1, cnt=0.
//     The first edge after release goes S_RST->S_OP.
//   - Fetch states (S_OP/S_LO/S_HI): mem_oe=0, oe_addr_ip=0.
//     cnt = mem_ready & ~flush, combinational, so IP advances on the same edge
//     that latches the byte.
//   - Length decode from opcode[7:6]:
//     00 -> 1 byte, 01 -> 2 bytes (imm8), 10 -> 3 bytes (imm16), 11 -> 1 byte.
//   - S_OP, mem_ready=1: ir<=mem_di, imm<=0.
//     Go to S_LO if len>1, else S_HOLD.
//   - S_LO, mem_ready=1: imm[7:0]<=mem_di.
//     Go to S_HI if len=3, else S_HOLD.
//   - S_HI, mem_ready=1: imm[15:8]<=mem_di; go to S_HOLD.
//   - In any fetch state with mem_ready=0: hold state, no latch, cnt=0.
//   - S_HOLD: ir_valid=1; mem_oe=1, oe_addr_ip=1, cnt=0.
//     ir_ready=1 -> S_OP (ir_valid falls after that edge);
//     otherwise stay, with ir/imm stable.
//   - ir_valid is registered: it rises on the edge that latches the last byte.
//   - Latency with mem_ready=1: N-byte instruction valid N edges after entering
//     S_OP. One bubble cycle (S_OP re-entry) between instructions.
//   - flush=1 at an edge overrides everything (except reset):
//     next state=S_OP, ir_valid<=0, no byte latched, cnt=0 in that cycle.
//     This lets execute reload IP via we_l/we_h on the same edge.
//   - flush during S_HOLD with ir_ready=1: the flush wins and the instruction is
//     dropped; execute must not also consume it.
//   - IP wrap FFFF->0000 is handled by pointer_pair; this block does not observe it.
//
// STRUCTURE
//   - Shared package cpu_pkg: state encodings S_*; opcode length constants
//     LEN_1/LEN_2/LEN_3; function insn_len(opcode).
//   - Single module, no sub-modules.
//
// TESTING
//   1. Reset, then opcode 8'h12 with mem_ready=1 -> after 2 edges ir=12,
//      imm=0000, ir_valid=1; cnt high for exactly 1 cycle.
//   2. Bytes 8'h83,34,12 -> ir=83, imm=1234, ir_valid=1; cnt pulsed 3 times;
//      pointer_pair IP 0000->0003.
//   3. Opcode 8'h41 with mem_ready low for 2 cycles before the imm byte
//      8'hAB -> no cnt while low; imm=00AB when valid.
//   4. ir_valid=1 with ir_ready=0 for 3 cycles -> ir/imm stable, mem_oe=1,
//      IP unchanged; ir_ready=1 -> ir_valid=0 next cycle.
//   5. flush asserted in S_LO -> next cycle S_OP, ir_valid=0,
//      cnt=0 in the flush cycle; fetch restarts at the reloaded IP.
//   6. rst=0 asserted mid-S_HI -> ir=00, imm=0000, ir_valid=0 immediately
//      (async); fetch resumes 1 edge after release.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared CPU definitions for the fetch sequencer.
//   state_e  : fetch FSM state encodings
//   LEN_1..3 : instruction length in bytes
//   insn_len : opcode[7:6] -> instruction length
package cpu_pkg;

  typedef enum logic [2:0] {
    S_RST  = 3'd0,
    S_OP   = 3'd1,
    S_LO   = 3'd2,
    S_HI   = 3'd3,
    S_HOLD = 3'd4
  } state_e;

  typedef logic [1:0] len_t;

  localparam len_t LEN_1 = 2'd1;
  localparam len_t LEN_2 = 2'd2;
  localparam len_t LEN_3 = 2'd3;

  // 00 and 11 are both single-byte opcodes.
  function automatic len_t insn_len(input logic [7:0] opcode);
    len_t len;
    case (opcode[7:6])
      2'b01:   len = LEN_2;
      2'b10:   len = LEN_3;
      default: len = LEN_1;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Bundle between the fetch sequencer, memory, pointer_pair and execute.
//   mem_di/mem_ready  : memory read data and its valid strobe
//   flush             : drop in-flight instruction (IP reload)
//   ir_ready          : execute accepts ir/imm
//   mem_oe/oe_addr_ip : active-low read enable / IP-on-address-bus
//   cnt               : IP increment strobe to pointer_pair
//   ir/imm/ir_valid   : assembled instruction toward execute
// master = fetch unit, slave = its environment.
interface fetch_if;
  logic [7:0]  mem_di;
  logic        mem_ready;
  logic        flush;
  logic        ir_ready;
  logic        mem_oe;
  logic        oe_addr_ip;
  logic        cnt;
  logic [7:0]  ir;
  logic [15:0] imm;
  logic        ir_valid;

  modport master (
    input  mem_di, mem_ready, flush, ir_ready,
    output mem_oe, oe_addr_ip, cnt, ir, imm, ir_valid
  );

  modport slave (
    output mem_di, mem_ready, flush, ir_ready,
    input  mem_oe, oe_addr_ip, cnt, ir, imm, ir_valid
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer. Reads one byte per cycle at IP, assembles an
// opcode plus 0/1/2 immediate bytes into ir/imm and offers it to execute
// with a valid/ready handshake.
//   clk  : system clock, rising edge
//   rst  : asynchronous, active-low reset
//   bus  : fetch_if.master (memory, pointer_pair and execute signals)
module fetch_unit
  import cpu_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  fetch_if.master  bus
);

  state_e      state_q, state_d;
  logic [7:0]  ir_q, ir_d;
  logic [15:0] imm_q, imm_d;
  logic        valid_q, valid_d;
  logic        fetching;
  logic        take_byte;

  assign fetching  = (state_q == S_OP) || (state_q == S_LO) || (state_q == S_HI);
  // A byte is consumed only when memory delivers it and no flush is pending.
  assign take_byte = fetching && bus.mem_ready && !bus.flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_RST;
      ir_q    <= '0;
      imm_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      imm_q   <= imm_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RST:  state_d = S_OP;
      S_OP:   if (bus.mem_ready)
                state_d = (insn_len(bus.mem_di) != LEN_1) ? S_LO : S_HOLD;
      S_LO:   if (bus.mem_ready)
                state_d = (insn_len(ir_q) == LEN_3) ? S_HI : S_HOLD;
      S_HI:   if (bus.mem_ready) state_d = S_HOLD;
      S_HOLD: if (bus.ir_ready) state_d = S_OP;
      default: state_d = S_RST;
    endcase
    // Flush beats everything, including a concurrent handshake in S_HOLD.
    if (bus.flush) state_d = S_OP;
  end

  always_comb begin
    ir_d  = ir_q;
    imm_d = imm_q;
    if (take_byte) begin
      case (state_q)
        S_OP: begin
          ir_d  = bus.mem_di;
          imm_d = '0;
        end
        S_LO:    imm_d[7:0]  = bus.mem_di;
        S_HI:    imm_d[15:8] = bus.mem_di;
        default: ;
      endcase
    end
    // Valid exactly while the next state is the hold state; flush therefore
    // clears it because it forces S_OP.
    valid_d = (state_d == S_HOLD);
  end

  always_comb begin
    bus.mem_oe     = !fetching;
    bus.oe_addr_ip = !fetching;
    bus.cnt        = take_byte;
  end

  assign bus.ir       = ir_q;
  assign bus.imm      = imm_q;
  assign bus.ir_valid = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit. A small pointer_pair/memory model
// supplies bytes; expected instructions go into a queue that a monitor
// drains at every accepted handshake.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  fetch_if     bus ();

  logic [7:0]  mem [0:65535];
  logic [15:0] ip;
  logic [15:0] reloadVal;
  logic [23:0] expQ [$];
  int          checkCount;
  int          passCount;
  int          cntPulses;
  int          c0;

  fetch_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // pointer_pair IP half: reload on flush, increment on cnt
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           ip <= 16'h0000;
    else if (bus.flush) ip <= reloadVal;
    else if (bus.cnt)   ip <= ip + 16'h0001;
  end

  assign bus.mem_di = (!bus.mem_oe && !bus.oe_addr_ip) ? mem[ip] : 8'h00;

  always @(negedge clk) begin
    if (rst && bus.cnt) cntPulses++;
  end

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic applyStimulus(input logic mr, input logic fl, input logic rdy);
    bus.mem_ready = mr;
    bus.flush     = fl;
    bus.ir_ready  = rdy;
    @(posedge clk);
    #1;
  endtask

  // Monitor: each accepted handshake must match the oldest expectation.
  always @(negedge clk) begin
    if (rst && bus.ir_valid && bus.ir_ready && !bus.flush) begin
      if (expQ.size() == 0) begin
        checkOutput("handshake_unexpected", {8'h00, bus.ir, bus.imm}, 32'hFFFFFFFF);
      end else begin
        logic [23:0] e;
        e = expQ.pop_front();
        checkOutput("handshake_insn", {8'h00, bus.ir, bus.imm}, {8'h00, e});
      end
    end
  end

  initial begin
    checkCount = 0;
    passCount  = 0;
    cntPulses  = 0;
    reloadVal  = 16'h0000;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0000] = 8'h12;
    mem[16'h0001] = 8'h83; mem[16'h0002] = 8'h34; mem[16'h0003] = 8'h12;
    mem[16'h0004] = 8'h41; mem[16'h0005] = 8'hAB;
    mem[16'h0006] = 8'h85; mem[16'h0007] = 8'h55;
    mem[16'h0020] = 8'hC7;
    mem[16'h0021] = 8'h9A; mem[16'h0022] = 8'h11; mem[16'h0023] = 8'h22;

    bus.mem_ready = 1'b1;
    bus.flush     = 1'b0;
    bus.ir_ready  = 1'b0;
    rst = 1'b1;
    #2 rst = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("rst_ir", {24'h0, bus.ir}, 32'h0);
    checkOutput("rst_imm", {16'h0, bus.imm}, 32'h0);
    checkOutput("rst_valid", {31'h0, bus.ir_valid}, 32'h0);
    checkOutput("rst_mem_oe", {31'h0, bus.mem_oe}, 32'h1);
    checkOutput("rst_oe_addr_ip", {31'h0, bus.oe_addr_ip}, 32'h1);
    checkOutput("rst_cnt", {31'h0, bus.cnt}, 32'h0);

    // Test 1: single-byte opcode 12
    rst = 1'b1;
    cntPulses = 0;
    expQ.push_back(24'h12_0000);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("t1_valid_after_1", {31'h0, bus.ir_valid}, 32'h0);
    checkOutput("t1_mem_oe_fetch", {31'h0, bus.mem_oe}, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("t1_valid", {31'h0, bus.ir_valid}, 32'h1);
    checkOutput("t1_ir", {24'h0, bus.ir}, 32'h12);
    checkOutput("t1_imm", {16'h0, bus.imm}, 32'h0);
    checkOutput("t1_cnt_pulses", cntPulses, 32'd1);
    checkOutput("t1_ip", {16'h0, ip}, 32'h1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    bus.ir_ready = 1'b0;

    // Test 2: three-byte 83 34 12
    c0 = cntPulses;
    expQ.push_back(24'h83_1234);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("t2_valid_early", {31'h0, bus.ir_valid}, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("t2_valid", {31'h0, bus.ir_valid}, 32'h1);
    checkOutput("t2_ir", {24'h0, bus.ir}, 32'h83);
    checkOutput("t2_imm", {16'h0, bus.imm}, 32'h1234);
    checkOutput("t2_cnt_pulses", cntPulses - c0, 32'd3);
    checkOutput("t2_ip", {16'h0, ip}, 32'h4);

    // Test 4: held instruction while execute stalls
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("t4_mem_oe", {31'h0, bus.mem_oe}, 32'h1);
      checkOutput("t4_cnt", {31'h0, bus.cnt}, 32'h0);
    end
    checkOutput("t4_ir", {24'h0, bus.ir}, 32'h83);
    checkOutput("t4_imm", {16'h0, bus.imm}, 32'h1234);
    checkOutput("t4_ip", {16'h0, ip}, 32'h4);
    checkOutput("t4_valid_held", {31'h0, bus.ir_valid}, 32'h1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    bus.ir_ready = 1'b0;
    checkOutput("t4_valid_fall", {31'h0, bus.ir_valid}, 32'h0);

    // Test 3: 41 with two wait cycles before AB
    c0 = cntPulses;
    expQ.push_back(24'h41_00AB);
    applyStimulus(1'b1, 1'b0, 1'b0);
    bus.mem_ready = 1'b0;
    #1;
    checkOutput("t3_cnt_wait", {31'h0, bus.cnt}, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("t3_cnt_pulses_wait", cntPulses - c0, 32'd1);
    checkOutput("t3_valid_wait", {31'h0, bus.ir_valid}, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("t3_valid", {31'h0, bus.ir_valid}, 32'h1);
    checkOutput("t3_ir", {24'h0, bus.ir}, 32'h41);
    checkOutput("t3_imm", {16'h0, bus.imm}, 32'h00AB);
    checkOutput("t3_ip", {16'h0, ip}, 32'h6);
    applyStimulus(1'b1, 1'b0, 1'b1);
    bus.ir_ready = 1'b0;

    // Test 5: flush in S_LO, reload IP to 0020
    applyStimulus(1'b1, 1'b0, 1'b0);
    reloadVal = 16'h0020;
    bus.mem_ready = 1'b1;
    bus.flush     = 1'b1;
    #1;
    checkOutput("t5_cnt_flush", {31'h0, bus.cnt}, 32'h0);
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    checkOutput("t5_valid", {31'h0, bus.ir_valid}, 32'h0);
    checkOutput("t5_ip_reload", {16'h0, ip}, 32'h20);
    checkOutput("t5_mem_oe", {31'h0, bus.mem_oe}, 32'h0);
    expQ.push_back(24'hC7_0000);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("t5_ir", {24'h0, bus.ir}, 32'hC7);
    checkOutput("t5_imm", {16'h0, bus.imm}, 32'h0);
    checkOutput("t5_valid_new", {31'h0, bus.ir_valid}, 32'h1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    bus.ir_ready = 1'b0;

    // Test 6: async reset in S_HI
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("t6_imm_pre", {16'h0, bus.imm}, 32'h0011);
    #2 rst = 1'b0;
    #1;
    checkOutput("t6_ir", {24'h0, bus.ir}, 32'h0);
    checkOutput("t6_imm", {16'h0, bus.imm}, 32'h0);
    checkOutput("t6_valid", {31'h0, bus.ir_valid}, 32'h0);
    checkOutput("t6_mem_oe", {31'h0, bus.mem_oe}, 32'h1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("t6_resume_mem_oe", {31'h0, bus.mem_oe}, 32'h0);
    expQ.push_back(24'h12_0000);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("t6_valid_resume", {31'h0, bus.ir_valid}, 32'h1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("queue_drained", expQ.size(), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
